// File: rtl/cpu_main_fsm.sv
// Multi-cycle main control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath controls and the memory
// handshake, counts retired instructions and latches a sticky trap status.
module cpu_main_fsm #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp,
  output logic             regbit,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_ILL
  } cls_t;

  state_t              state_q, state_d;
  cls_t                dec_cls, op_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                wait_hit;
  logic                stall;
  logic [1:0]          ctl_src_a, ctl_src_b, ctl_aluop;
  logic                ctl_regbit;

  // The request that would push the stall count to WAIT_LIMIT times out.
  assign wait_hit = (WAIT_LIMIT != 0) && (wait_q == WAIT_W'(WAIT_LIMIT - 1));
  assign stall    = mem_req && !mem_ready;

  // Classify the opcode presented by the IR.
  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      OP_R:      dec_cls = C_R;
      OP_I:      dec_cls = C_I;
      OP_LOAD:   dec_cls = C_LOAD;
      OP_STORE:  dec_cls = C_STORE;
      OP_BRANCH: dec_cls = C_BRANCH;
      OP_JAL:    dec_cls = C_JAL;
      OP_JALR:   dec_cls = C_JALR;
      OP_LUI:    dec_cls = C_LUI;
      OP_AUIPC:  dec_cls = C_AUIPC;
      default:   dec_cls = C_ILL;
    endcase
  end

  // ALU operand and operation selects for the latched instruction class.
  always_comb begin
    ctl_src_a  = 2'd0;
    ctl_src_b  = 2'd0;
    ctl_aluop  = 2'd0;
    ctl_regbit = 1'b0;
    case (op_q)
      C_R:      ctl_regbit = 1'b1;
      C_I:      ctl_src_b  = 2'd1;
      C_LOAD,
      C_STORE,
      C_JALR: begin
        ctl_src_b = 2'd1;
        ctl_aluop = 2'd1;
      end
      C_LUI: begin
        ctl_src_a = 2'd2;
        ctl_src_b = 2'd1;
        ctl_aluop = 2'd1;
      end
      C_AUIPC: begin
        ctl_src_a = 2'd1;
        ctl_src_b = 2'd1;
        ctl_aluop = 2'd1;
      end
      C_JAL:    ctl_aluop = 2'd1;
      C_BRANCH: ctl_aluop = 2'd2;
      default: begin
        ctl_src_a = 2'd0;
      end
    endcase
  end

  // Next-state and control decode; everything is held low while in reset.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    ALUOp     = 2'd0;
    regbit    = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src_a = ctl_src_a;
      alu_src_b = ctl_src_b;
      ALUOp     = ctl_aluop;
      regbit    = ctl_regbit;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        state_d = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (op_q == C_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = br_cond ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (op_q == C_LOAD || op_q == C_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == C_STORE);
        if (mem_ready) begin
          if (op_q == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (op_q == C_LOAD) begin
          wb_sel = 2'd1;
        end else if (op_q == C_JAL || op_q == C_JALR) begin
          wb_sel = 2'd2;
        end
        if (op_q == C_JAL) begin
          pc_sel = 2'd1;
        end else if (op_q == C_JALR) begin
          pc_sel = 2'd2;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      ALUOp     = 2'd0;
      regbit    = 1'b0;
    end
  end

  // State, latched class, stall counter, trap status and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      op_q       <= C_R;
      wait_q     <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      instret    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_DECODE) begin
        op_q <= dec_cls;
      end

      // Count consecutive stalls of one request; any completion or exit clears.
      if (stall && state_d == state_q) begin
        if (wait_q != '1) begin
          wait_q <= wait_q + WAIT_W'(1);
        end
      end else begin
        wait_q <= '0;
      end

      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= (state_q == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end

      if (pc_we) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_main_fsm.sv
// Randomized bench for cpu_main_fsm: each instruction's cycle-by-cycle control
// trace is built from its class and planned memory stalls, then compared.
module tb_cpu_main_fsm;

  localparam int unsigned WL = 4;
  localparam int unsigned CW = 4;

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] aluop;
    logic       regbit;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic          br_cond = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, ir_we, pc_we, rf_we, regbit, trap;
  logic [1:0]    pc_sel, wb_sel, alu_src_a, alu_src_b, ALUOp, trap_cause;
  logic [CW-1:0] instret;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_instret = 0;
  logic       exp_trap = 1'b0;
  logic [1:0] exp_cause = 2'd0;

  always #5 clk = ~clk;

  cpu_main_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_cond(br_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .regbit(regbit), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  function automatic logic [6:0] opc_of(input int c, input int pick);
    case (c)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LOAD:  return 7'b0000011;
      C_STORE: return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LUI:   return 7'b0110111;
      C_AUIPC: return 7'b0010111;
      default: begin
        case (pick % 4)
          0:       return 7'b0000000;
          1:       return 7'b1111111;
          2:       return 7'b0001111;
          default: return 7'b1110011;
        endcase
      end
    endcase
  endfunction

  // ALU selects an instruction class holds from EXEC through its last cycle.
  function automatic ctl_t alu_ctl(input int c);
    ctl_t e;
    e = '0;
    case (c)
      C_R:                   e.regbit = 1'b1;
      C_I:                   e.src_b = 2'd1;
      C_LOAD, C_STORE, C_JALR: begin e.src_b = 2'd1; e.aluop = 2'd1; end
      C_LUI:   begin e.src_a = 2'd2; e.src_b = 2'd1; e.aluop = 2'd1; end
      C_AUIPC: begin e.src_a = 2'd1; e.src_b = 2'd1; e.aluop = 2'd1; end
      C_JAL:                 e.aluop = 2'd1;
      C_BR:                  e.aluop = 2'd2;
      default:               e.aluop = 2'd0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance.
  task automatic cyc(input string tag, input ctl_t e, input logic [15:0] m,
                     input logic rdy, input logic [6:0] op, input logic br);
    logic [15:0] obs;
    mem_ready = e.mem_req ? rdy : 1'($urandom);
    opcode    = op;
    br_cond   = br;
    #1;
    obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
           alu_src_a, alu_src_b, ALUOp, regbit};
    check({tag, "_ctl"}, 64'(obs & m), 64'(e & m));
    check({tag, "_st"}, 64'({trap, trap_cause, instret}),
          64'({exp_trap, exp_cause, CW'(exp_instret)}));
    @(negedge clk);
    if (e.pc_we) exp_instret = (exp_instret + 1) % (1 << CW);
  endtask

  task automatic do_reset();
    logic [15:0] obs;
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 7'($urandom);
    exp_trap = 1'b0;
    exp_cause = 2'd0;
    exp_instret = 0;
    #1;
    obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
           alu_src_a, alu_src_b, ALUOp, regbit};
    check("rst_ctl", 64'(obs), 64'd0);
    check("rst_st", 64'({trap, trap_cause, instret}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic trap_hold(input int cause);
    exp_trap = 1'b1;
    exp_cause = 2'(cause);
    repeat (3) cyc("trap", '0, 16'hFFFF, 1'($urandom), 7'($urandom), 1'($urandom));
    do_reset();
  endtask

  // One instruction: sf/sm stall cycles in fetch/mem, rst_mem = mem cycle to reset in (-1 none).
  task automatic run_instr(input int c, input int sf, input int sm, input logic br, input int rst_mem);
    ctl_t        e;
    logic [6:0]  op;
    logic [15:0] m;
    op = opc_of(c, int'($urandom_range(0, 3)));
    m  = (c == C_JAL) ? 16'hFF87 : 16'hFFFF;
    for (int k = 0; k <= sf; k++) begin
      e = '0;
      e.mem_req = 1'b1;
      if (k < sf) begin
        cyc("fetch_wait", e, 16'hFFFF, 1'b0, 7'($urandom), 1'($urandom));
        if (k + 1 == int'(WL)) begin trap_hold(2); return; end
      end else begin
        e.ir_we = 1'b1;
        cyc("fetch", e, 16'hFFFF, 1'b1, 7'($urandom), 1'($urandom));
      end
    end
    cyc("decode", '0, 16'hFFFF, 1'($urandom), op, 1'($urandom));
    if (c == C_ILL) begin trap_hold(1); return; end
    e = alu_ctl(c);
    if (c == C_BR) begin
      e.pc_we = 1'b1;
      e.pc_sel = br ? 2'd1 : 2'd0;
    end
    cyc("exec", e, m, 1'($urandom), op, (c == C_BR) ? br : 1'($urandom));
    if (c == C_BR) return;
    if (c == C_LOAD || c == C_STORE) begin
      for (int k = 0; k <= sm; k++) begin
        e = alu_ctl(c);
        e.mem_req = 1'b1;
        e.mem_we = (c == C_STORE);
        if (k == rst_mem) begin do_reset(); return; end
        if (k < sm) begin
          cyc("mem_wait", e, m, 1'b0, op, 1'($urandom));
          if (k + 1 == int'(WL)) begin trap_hold(2); return; end
        end else begin
          if (c == C_STORE) e.pc_we = 1'b1;
          cyc("mem", e, m, 1'b1, op, 1'($urandom));
        end
      end
      if (c == C_STORE) return;
    end
    e = alu_ctl(c);
    e.rf_we = 1'b1;
    e.pc_we = 1'b1;
    e.wb_sel = (c == C_LOAD) ? 2'd1 : ((c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0);
    e.pc_sel = (c == C_JAL) ? 2'd1 : ((c == C_JALR) ? 2'd2 : 2'd0);
    cyc("wb", e, m, 1'($urandom), op, 1'($urandom));
  endtask

  function automatic int pick_stall();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(4, 5));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    int c;
    int sm;
    int rm;
    @(negedge clk);
    do_reset();
    // Directed steps
    run_instr(C_R,     0, 0, 1'b0, -1);
    run_instr(C_LOAD,  0, 3, 1'b0, -1);
    run_instr(C_BR,    0, 0, 1'b1, -1);
    run_instr(C_BR,    0, 0, 1'b0, -1);
    run_instr(C_JALR,  0, 0, 1'b0, -1);
    run_instr(C_I,     3, 0, 1'b0, -1);
    run_instr(C_STORE, 1, 2, 1'b0, -1);
    run_instr(C_JAL,   0, 0, 1'b0, -1);
    run_instr(C_LUI,   2, 0, 1'b0, -1);
    run_instr(C_AUIPC, 0, 0, 1'b0, -1);
    run_instr(C_ILL,   0, 0, 1'b0, -1);
    run_instr(C_R,     4, 0, 1'b0, -1);
    run_instr(C_LOAD,  0, 3, 1'b0, 1);
    run_instr(C_STORE, 0, 5, 1'b0, -1);
    // Long trap-free run so the narrow retire counter wraps
    for (int i = 0; i < 20; i++)
      run_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom), -1);
    // Random mix including illegal opcodes, timeouts and mid-MEM resets
    for (int i = 0; i < 80; i++) begin
      c  = ($urandom_range(0, 15) == 0) ? C_ILL : int'($urandom_range(0, 8));
      sm = pick_stall();
      rm = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, sm)) : -1;
      run_instr(c, pick_stall(), sm, 1'($urandom), rm);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cpu_main_fsm.md
Name: cpu_main_fsm

Overview:
Multi-cycle main control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the ALU control inputs (ALUOp, regbit), datapath mux selects and write enables, and the memory request handshake. It also keeps a retired-instruction counter and a sticky trap status.

Parameters:
WAIT_LIMIT, 255, max consecutive stall cycles on a memory request before a timeout trap; 0 disables the timeout
CNT_W, 32, width of the instret counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0]; valid from DECODE onward
br_cond  input  1  branch comparator result for the current IR funct3
mem_ready  input  1  memory accepts or completes the request this cycle
mem_req  output  1  memory request
mem_we  output  1  1 = store, 0 = read/fetch
ir_we  output  1  latch instruction into IR
pc_we  output  1  update PC
pc_sel  output  2  0 = PC+4, 1 = PC+imm (branch adder), 2 = ALU result with bit 0 cleared
rf_we  output  1  register file write
wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4
alu_src_a  output  2  0 = rs1, 1 = PC, 2 = zero
alu_src_b  output  2  0 = rs2, 1 = imm
ALUOp  output  2  0 = funct-decoded, 1 = add, 2 = subtract
regbit  output  1  1 for R-type (opcode 0110011)
trap  output  1  sticky halt flag
trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = memory timeout
instret  output  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore-style, decoded from the state and the registered opcode.
- Reset: state=FETCH, instret=0, trap=0, trap_cause=0, wait counter=0. While rst=1, every output is forced to 0. The first mem_req appears in the first cycle after rst is released.
- Reset mid-instruction aborts it immediately. No partial write is issued after rst rises.
- Defaults in every state: all enables 0, selects 0, ALUOp=0, regbit=0.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_we=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Supported opcodes (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) go to EXEC.
  - Any other opcode goes to TRAP with cause 1.
- EXEC controls, held unchanged into MEM/WB of the same instruction:
  - R-type: src_a=0, src_b=0, ALUOp=0, regbit=1.
  - I-ALU: src_a=0, src_b=1, ALUOp=0.
  - LOAD, STORE, JALR: src_a=0, src_b=1, ALUOp=1.
  - LUI: src_a=2, src_b=1, ALUOp=1.
  - AUIPC: src_a=1, src_b=1, ALUOp=1.
  - JAL: ALU is don't-care, ALUOp=1.
  - BRANCH: src_a=0, src_b=0, ALUOp=2.
- EXEC next state:
  - BRANCH retires in EXEC: pc_we=1, pc_sel = br_cond ? 1 : 0, then FETCH.
  - LOAD and STORE go to MEM.
  - All others go to WB.
- MEM:
  - mem_req=1, mem_we=1 for STORE and 0 for LOAD.
  - Wait for mem_ready.
  - STORE retires on mem_ready: pc_we=1, pc_sel=0, then FETCH.
  - LOAD goes to WB on mem_ready.
- WB:
  - rf_we=1 and pc_we=1, then FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
- Latency with zero-wait memory: BRANCH 3 cycles; R/I/LUI/AUIPC/JAL/JALR 4; STORE 4; LOAD 5. Each stall cycle adds 1.
- mem_ready is ignored when mem_req=0. A same-cycle mem_ready, combinational from mem_req, is legal.
- Wait counter:
  - Increments each cycle that mem_req=1 and mem_ready=0.
  - Clears on mem_ready and on leaving FETCH/MEM.
  - With WAIT_LIMIT≠0, the cycle in which the counter would reach WAIT_LIMIT goes to TRAP with cause 2.
  - mem_ready in that same cycle wins: no trap.
- TRAP: all enables 0, trap=1, trap_cause held. Only rst exits TRAP. An instruction that traps is not counted.
- instret increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W. It never increments in TRAP.

Test Plan:
- R-type ADD (opcode 0110011), mem_ready tied 1 -> states FETCH,DECODE,EXEC,WB; ALUOp=0/regbit=1 in EXEC+WB; rf_we=1, pc_we=1, pc_sel=0 in cycle 4; instret 0->1.
- LOAD with mem_ready low 3 cycles in MEM -> mem_req=1, mem_we=0 held for 4 cycles; WB wb_sel=1, rf_we=1; total 8 cycles.
- BEQ with br_cond=1, then br_cond=0 -> EXEC ALUOp=2, pc_we=1 with pc_sel=1 then 0; rf_we never 1; 3 cycles each.
- JALR -> EXEC ALUOp=1, src_b=1; WB rf_we=1, wb_sel=2, pc_sel=2.
- opcode 0000000 in DECODE -> TRAP next cycle, trap=1, trap_cause=1, no further mem_req, instret unchanged; rst clears to FETCH.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> TRAP with trap_cause=2 on the 4th stall cycle. With ready asserted on that 4th cycle -> no trap, DECODE. rst asserted mid-MEM -> outputs 0 immediately.
